// File: rtl/fp_norm_arbiter.sv
// fp_norm_arbiter: round-robin sharing of one ce-stallable normalizer pipeline among NREQ requesters
module fp_norm_arbiter #(
  parameter int NREQ = 4,
  parameter int IWID = 128,
  parameter int OWID = 68,
  parameter int LAT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*IWID-1:0] arg_i,
  input  logic [NREQ-1:0]      under_req_i,
  output logic [NREQ-1:0]      ack_o,
  input  logic                 flush_i,
  output logic                 norm_ce_o,
  output logic [IWID-1:0]      norm_i_o,
  output logic                 norm_under_o,
  input  logic [OWID-1:0]      norm_o_i,
  input  logic                 norm_under_i,
  input  logic                 norm_inexact_i,
  output logic                 res_valid_o,
  input  logic                 res_ready_i,
  output logic [2:0]           res_id_o,
  output logic [OWID-1:0]      res_o,
  output logic                 res_under_o,
  output logic                 res_inexact_o,
  output logic                 busy_o
);
  logic [7:0]      req_x, under_x;
  logic [IWID-1:0] arg_a [8];
  logic [3:0]      sum;
  logic [2:0]      gnt_idx, ptr_q, ptr_d;
  logic            gnt_any, go;
  logic [LAT-1:0]  vld_q;
  logic [2:0]      id_q [LAT];
  logic            res_valid_q, res_under_q, res_inexact_q;
  logic [2:0]      res_id_q;
  logic [OWID-1:0] res_q;
  assign req_x   = 8'(req_i);
  assign under_x = 8'(under_req_i);
  for (genvar g = 0; g < 8; g++) begin : g_arg
    if (g < NREQ) begin : g_used
      assign arg_a[g] = arg_i[g*IWID +: IWID];
    end else begin : g_unused
      assign arg_a[g] = '0;
    end
  end
  // pick the first requester at or after ptr; scanning backwards lets the nearest one win
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      sum = {1'b0, ptr_q} + 4'(j);
      sum = sum >= 4'(NREQ) ? sum - 4'(NREQ) : sum;
      if (req_x[sum[2:0]]) begin
        gnt_any = 1'b1;
        gnt_idx = sum[2:0];
      end
    end
  end
  assign norm_ce_o    = ~res_valid_q | res_ready_i;
  assign go           = gnt_any & norm_ce_o & ~flush_i & ~rst;
  assign ack_o        = go ? NREQ'(8'd1 << gnt_idx) : '0;
  assign norm_i_o     = go ? arg_a[gnt_idx] : '0;
  assign norm_under_o = go & under_x[gnt_idx];
  assign ptr_d        = go ? (gnt_idx == 3'(NREQ - 1) ? 3'd0 : gnt_idx + 3'd1) : ptr_q;
  assign busy_o       = |vld_q | res_valid_q;
  assign res_valid_o   = res_valid_q;
  assign res_id_o      = res_id_q;
  assign res_o         = res_q;
  assign res_under_o   = res_under_q;
  assign res_inexact_o = res_inexact_q;
  // round-robin pointer and in-flight valid tracking; flush and reset drop all in-flight work
  always_ff @(posedge clk) begin
    ptr_q <= rst ? 3'd0 : ptr_d;
    if (rst || flush_i) vld_q <= '0;
    else if (norm_ce_o) vld_q <= {vld_q[LAT-2:0], go};
  end
  // requester IDs ride alongside the normalizer pipeline; stale entries are masked by vld_q
  always_ff @(posedge clk) begin
    if (norm_ce_o) begin
      id_q[0] <= gnt_idx;
      for (int i = 1; i < LAT; i++) id_q[i] <= id_q[i-1];
    end
  end
  // result register: data captured only for tracked ops, held while the consumer stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      res_valid_q   <= 1'b0;
      res_id_q      <= '0;
      res_q         <= '0;
      res_under_q   <= 1'b0;
      res_inexact_q <= 1'b0;
    end else if (flush_i) begin
      res_valid_q <= 1'b0;
    end else if (norm_ce_o) begin
      res_valid_q <= vld_q[LAT-1];
      if (vld_q[LAT-1]) begin
        res_id_q      <= id_q[LAT-1];
        res_q         <= norm_o_i;
        res_under_q   <= norm_under_i;
        res_inexact_q <= norm_inexact_i;
      end
    end
  end
endmodule

// File: tb/tb_fp_norm_arbiter.sv
// tb_fp_norm_arbiter: randomized and directed checks of fp_norm_arbiter against a queue-based model
module tb_fp_norm_arbiter;
  localparam int N = 4, IW = 128, OW = 68, L = 8;
  typedef struct { int id; logic [OW+1:0] r; int cnt; } ent_t;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, ready = 1'b1;
  logic [N-1:0] req = '0, under_v = '0, ack;
  logic [IW-1:0] argv [N];
  logic [N*IW-1:0] arg_bus;
  logic n_ce, n_under, n_uin, n_xin, res_valid, res_under, res_inexact, busy;
  logic [IW-1:0] n_i;
  logic [OW-1:0] n_o, res_o;
  logic [2:0] res_id;
  logic [OW+1:0] pipe [L];
  ent_t q[$];
  int checks = 0, errors = 0, mptr = 0, eg;
  logic ev, ece;
  logic [N-1:0] eack;

  fp_norm_arbiter #(.NREQ(N), .IWID(IW), .OWID(OW), .LAT(L)) dut (
    .clk(clk), .rst(rst), .req_i(req), .arg_i(arg_bus), .under_req_i(under_v), .ack_o(ack),
    .flush_i(flush), .norm_ce_o(n_ce), .norm_i_o(n_i), .norm_under_o(n_under),
    .norm_o_i(n_o), .norm_under_i(n_uin), .norm_inexact_i(n_xin),
    .res_valid_o(res_valid), .res_ready_i(ready), .res_id_o(res_id), .res_o(res_o),
    .res_under_o(res_under), .res_inexact_o(res_inexact), .busy_o(busy)
  );

  always #5 clk = ~clk;
  assign arg_bus = {argv[3], argv[2], argv[1], argv[0]};

  // stand-in normalizer: arbitrary deterministic function through an L-stage ce-gated pipe
  function automatic logic [OW+1:0] nf(input logic [IW-1:0] a, input logic u);
    return {^a[7:0], u ^ a[127], a[67:0] ^ {a[127:68], 8'h00}};
  endfunction
  always @(posedge clk) begin
    if (n_ce) begin
      pipe[0] <= nf(n_i, n_under);
      for (int i = 1; i < L; i++) pipe[i] <= pipe[i-1];
    end
  end
  assign {n_xin, n_uin, n_o} = pipe[L-1];

  function automatic logic [IW-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // model: each accepted op is a queue entry counting down L+1 ce-cycles before it is presented
  task automatic sample();
    @(negedge clk);
    ev  = q.size() > 0 && q[0].cnt == 0;
    ece = !ev || ready;
    eg  = -1;
    if (!rst && !flush && ece)
      for (int j = 0; j < N; j++)
        if (eg < 0 && ((int'(req) >> ((mptr + j) % N)) & 1) == 1) eg = (mptr + j) % N;
    eack = eg < 0 ? '0 : N'(1 << eg);
  endtask

  task automatic advance();
    int g;
    g = -1;
    @(posedge clk);
    if (rst) begin
      q.delete();
      mptr = 0;
    end else if (flush) q.delete();
    else if (ece) begin
      if (ev) void'(q.pop_front());
      foreach (q[i]) q[i].cnt--;
      if (eg >= 0) begin
        q.push_back('{id: eg, r: nf(argv[eg], under_v[eg]), cnt: L});
        mptr = (eg + 1) % N;
        g = eg;
      end
    end
    #1;
    if (g >= 0) begin
      argv[g] = rnd();
      under_v[g] = 1'($urandom_range(1));
    end
  endtask

  task automatic test_reset();
    req = '1;
    repeat (2) @(posedge clk);
    #1;
    sample();
    checks += 5;
    if (ack !== '0) begin errors++; $display("FAIL reset ack: got %b exp 0", ack); end
    if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL reset valid/busy: got %b/%b exp 0/0", res_valid, busy); end
    if (n_ce !== 1'b1) begin errors++; $display("FAIL reset ce: got %b exp 1", n_ce); end
    if (n_i !== '0 || n_under !== 1'b0) begin errors++; $display("FAIL reset norm_i: got %h/%b exp 0/0", n_i, n_under); end
    if (res_id !== 3'd0 || res_o !== '0 || res_under !== 1'b0 || res_inexact !== 1'b0)
      begin errors++; $display("FAIL reset res: got id %0d o %h u %b x %b exp zeros", res_id, res_o, res_under, res_inexact); end
    advance();
    rst = 1'b0;
    req = '0;
  endtask

  task automatic test_traffic(input int n, input int p_req, input int p_rdy, input int p_fl);
    for (int c = 0; c < n; c++) begin
      req   = $urandom_range(99) < p_req ? N'($urandom()) : '0;
      ready = $urandom_range(99) < p_rdy;
      flush = $urandom_range(99) < p_fl;
      sample();
      checks += 4;
      if (ack !== eack) begin errors++; $display("FAIL traffic ack: got %b exp %b", ack, eack); end
      if (n_ce !== ece) begin errors++; $display("FAIL traffic ce: got %b exp %b", n_ce, ece); end
      if (res_valid !== ev) begin errors++; $display("FAIL traffic valid: got %b exp %b", res_valid, ev); end
      if (busy !== (q.size() > 0)) begin errors++; $display("FAIL traffic busy: got %b exp %0d", busy, q.size() > 0); end
      if (ev) begin
        checks += 2;
        if (res_id !== 3'(q[0].id)) begin errors++; $display("FAIL traffic id: got %0d exp %0d", res_id, q[0].id); end
        if ({res_inexact, res_under, res_o} !== q[0].r)
          begin errors++; $display("FAIL traffic data: got %h exp %h", {res_inexact, res_under, res_o}, q[0].r); end
      end
      if (eg >= 0) begin
        checks++;
        if (n_i !== argv[eg] || n_under !== under_v[eg])
          begin errors++; $display("FAIL traffic norm_i: got %h/%b exp %h/%b", n_i, n_under, argv[eg], under_v[eg]); end
      end
      advance();
    end
    req = '0;
    ready = 1'b1;
    flush = 1'b0;
  endtask

  task automatic test_all_four();
    req = '1;
    for (int c = 0; c < 16; c++) begin
      sample();
      checks++;
      if (ack !== N'(1 << (c % 4))) begin errors++; $display("FAIL all4 ack c%0d: got %b exp %b", c, ack, N'(1 << (c % 4))); end
      if (c >= L + 1) begin
        checks += 2;
        if (res_valid !== 1'b1 || res_id !== 3'((c - L - 1) % 4))
          begin errors++; $display("FAIL all4 result c%0d: got v%b id%0d exp v1 id%0d", c, res_valid, res_id, (c - L - 1) % 4); end
        if (!ev || {res_inexact, res_under, res_o} !== q[0].r)
          begin errors++; $display("FAIL all4 data c%0d: got %h exp %h", c, {res_inexact, res_under, res_o}, ev ? q[0].r : '0); end
      end
      advance();
    end
    req = '0;
  endtask

  task automatic test_single_op();
    logic [OW+1:0] exp_r;
    int t;
    argv[0] = rnd();
    under_v[0] = 1'b1;
    exp_r = nf(argv[0], 1'b1);
    req = 4'b0001;
    sample();
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL single ack: got %b exp 0001", ack); end
    advance();
    req = '0;
    t = 1;
    sample();
    while (res_valid !== 1'b1 && t < 20) begin
      advance();
      sample();
      t++;
    end
    checks += 3;
    if (t != L + 1) begin errors++; $display("FAIL single latency: got %0d exp %0d", t, L + 1); end
    if (res_id !== 3'd0) begin errors++; $display("FAIL single id: got %0d exp 0", res_id); end
    if ({res_inexact, res_under, res_o} !== exp_r)
      begin errors++; $display("FAIL single data: got %h exp %h", {res_inexact, res_under, res_o}, exp_r); end
    advance();
  endtask

  task automatic test_backpressure();
    logic [OW+4:0] snap;
    int t;
    req = '1;
    repeat (4) begin
      sample();
      checks++;
      if (ack !== eack) begin errors++; $display("FAIL bp issue ack: got %b exp %b", ack, eack); end
      advance();
    end
    req = '0;
    t = 0;
    sample();
    while (res_valid !== 1'b1 && t < 20) begin
      advance();
      sample();
      t++;
    end
    checks++;
    if (res_valid !== 1'b1 || !ev) begin errors++; $display("FAIL bp first result: got %b exp 1", res_valid); end
    advance();
    ready = 1'b0;
    req = '1;
    sample();
    snap = {res_id, res_inexact, res_under, res_o};
    for (int c = 0; c < 5; c++) begin
      if (c > 0) begin
        advance();
        sample();
      end
      checks += 3;
      if (n_ce !== 1'b0 || ack !== '0) begin errors++; $display("FAIL bp stall c%0d: got ce %b ack %b exp 0/0", c, n_ce, ack); end
      if (res_valid !== 1'b1) begin errors++; $display("FAIL bp valid c%0d: got %b exp 1", c, res_valid); end
      if ({res_id, res_inexact, res_under, res_o} !== snap)
        begin errors++; $display("FAIL bp stable c%0d: got %h exp %h", c, {res_id, res_inexact, res_under, res_o}, snap); end
    end
    advance();
    ready = 1'b1;
    req = '0;
  endtask

  task automatic test_rr_wrap();
    req = 4'b0100;
    sample();
    checks++;
    if (ack !== 4'b0100) begin errors++; $display("FAIL rr single ack: got %b exp 0100", ack); end
    advance();
    req = 4'b1001;
    sample();
    checks++;
    if (ack !== 4'b1000) begin errors++; $display("FAIL rr wrap ack1: got %b exp 1000", ack); end
    advance();
    sample();
    checks++;
    if (ack !== 4'b0001) begin errors++; $display("FAIL rr wrap ack2: got %b exp 0001", ack); end
    advance();
    req = '0;
  endtask

  task automatic test_reset_midflight();
    logic [OW+1:0] exp_r;
    int t;
    req = '1;
    repeat (L + 1) begin
      sample();
      checks++;
      if (ack !== eack) begin errors++; $display("FAIL rstmid issue ack: got %b exp %b", ack, eack); end
      advance();
    end
    rst = 1'b1;
    sample();
    checks += 2;
    if (res_valid !== 1'b1) begin errors++; $display("FAIL rstmid pre valid: got %b exp 1", res_valid); end
    if (ack !== '0) begin errors++; $display("FAIL rstmid ack in rst: got %b exp 0", ack); end
    advance();
    rst = 1'b0;
    sample();
    exp_r = nf(argv[0], under_v[0]);
    checks += 2;
    if (res_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid after: got v%b busy%b exp 0/0", res_valid, busy); end
    if (ack !== 4'b0001) begin errors++; $display("FAIL rstmid ptr: got ack %b exp 0001", ack); end
    advance();
    req = '0;
    t = 1;
    sample();
    while (res_valid !== 1'b1 && t < 20) begin
      advance();
      sample();
      t++;
    end
    checks += 2;
    if (t != L + 1 || res_id !== 3'd0) begin errors++; $display("FAIL rstmid result: got lat %0d id %0d exp %0d id 0", t, res_id, L + 1); end
    if ({res_inexact, res_under, res_o} !== exp_r)
      begin errors++; $display("FAIL rstmid data: got %h exp %h", {res_inexact, res_under, res_o}, exp_r); end
    advance();
  endtask

  task automatic test_flush();
    int p;
    req = '1;
    repeat (3) begin
      sample();
      checks++;
      if (ack !== eack) begin errors++; $display("FAIL flush issue ack: got %b exp %b", ack, eack); end
      advance();
    end
    p = mptr;
    flush = 1'b1;
    req = 4'b0010;
    sample();
    checks++;
    if (ack !== '0 || busy !== 1'b1) begin errors++; $display("FAIL flush cycle: got ack %b busy %b exp 0/1", ack, busy); end
    advance();
    flush = 1'b0;
    req = '1;
    sample();
    checks += 2;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin errors++; $display("FAIL flush after: got busy %b v %b exp 0/0", busy, res_valid); end
    if (ack !== N'(1 << p)) begin errors++; $display("FAIL flush ptr: got ack %b exp %b", ack, N'(1 << p)); end
    advance();
    req = '0;
  endtask

  initial begin
    for (int k = 0; k < N; k++) argv[k] = rnd();
    test_reset();
    test_all_four();
    test_traffic(14, 0, 100, 0);
    test_single_op();
    test_backpressure();
    test_traffic(20, 0, 100, 0);
    test_rr_wrap();
    test_traffic(14, 0, 100, 0);
    test_reset_midflight();
    test_flush();
    test_traffic(14, 0, 100, 0);
    test_traffic(400, 60, 70, 2);
    test_traffic(20, 0, 100, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fp_norm_arbiter.md
Name: fp_norm_arbiter

Overview:
- Shares one fpNormalize instance (8-cycle, ce-stallable pipeline) among NREQ requesters.
- Round-robin selects one request per cycle and issues it into the normalizer.
- Tracks in-flight operations with a valid/ID shift register matched to the normalizer latency.
- Returns each result with its requester ID through a registered valid/ready output port, applying backpressure by deasserting the normalizer ce.

Parameters:
NREQ, 4, number of requesters (2..8)
IWID, 128, width of expanded-format operand (normalizer input i)
OWID, 68, width of normalizer output o
LAT, 8, normalizer latency in ce-enabled cycles

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_i  in  NREQ  per-requester request; operand held stable until acked
arg_i  in  NREQ*IWID  per-requester operand, slice k = requester k
under_req_i  in  NREQ  per-requester underflow flag
ack_o  out  NREQ  one-hot, combinational; request accepted this cycle
flush_i  in  1  synchronous discard of all in-flight work
norm_ce_o  out  1  ce to normalizer
norm_i_o  out  IWID  operand to normalizer
norm_under_o  out  1  under_i to normalizer
norm_o_i  in  OWID  normalizer o
norm_under_i  in  1  normalizer under_o
norm_inexact_i  in  1  normalizer inexact_o
res_valid_o  out  1  result valid
res_ready_i  in  1  consumer accepts result
res_id_o  out  3  requester index of result
res_o  out  OWID  registered result
res_under_o  out  1  registered underflow
res_inexact_o  out  1  registered inexact
busy_o  out  1  any op in flight or result pending

Behaviour:
- norm_ce_o = !res_valid_o | res_ready_i. When norm_ce_o=0, nothing advances: no ack, shift register frozen, normalizer frozen.
- Arbitration: round-robin pointer ptr (0..NREQ-1, reset 0). Grant goes to the first k with req_i[k]=1, searching ptr, ptr+1, ... modulo NREQ.
- Grant happens only when norm_ce_o=1 and flush_i=0. ack_o[k]=1 for exactly one cycle. After a grant to k, ptr <= (k+1) mod NREQ; otherwise ptr holds.
- norm_i_o / norm_under_o = arg/under of the granted requester. When nothing is granted they are 0.
- Tracking: vld[0..LAT-1] and id[0..LAT-1] shift by one on each ce=1 cycle. vld[0] <= grant, id[0] <= granted index.
- Output register, on a ce=1 cycle:
  - res_valid_o <= vld[LAT-1]
  - res_o, res_under_o, res_inexact_o <= norm inputs
  - res_id_o <= id[LAT-1]
- Result data is captured only when vld[LAT-1]=1; otherwise data holds and res_valid_o clears.
- Latency: ack in cycle T gives res_valid_o=1 in cycle T+LAT+1 when unstalled. Throughput is 1 op/cycle.
- While stalled (res_valid_o=1, res_ready_i=0), all res_* outputs are stable.
- flush_i (and rst) clear vld[*] and res_valid_o and suppress grants that cycle.
  - rst also clears ptr, res_id_o, res_o, res_under_o and res_inexact_o.
  - flush_i preserves ptr.
  - The normalizer's contents are garbage afterwards and are masked by vld.
- Reset values: ack_o=0, res_valid_o=0, busy_o=0, norm_ce_o=1, norm_i_o=0, norm_under_o=0, res_id_o=0, res_o=0, flags 0.
- busy_o = |vld | res_valid_o.
- Requests withdrawn without ack are legal and ignored. A request asserted in the same cycle as a stall waits.
- A single requester holding req_i is granted every unstalled cycle.

Test Plan:
- Single op: req_i=0001, arg=A at T -> ack_o=0001 at T; res_valid_o=1 at T+9, res_id_o=0, res_o equals a standalone normalizer result for A.
- All four requesting continuously from ptr=0 -> acks 0,1,2,3,0,1,... one per cycle; results emerge in the same ID order, back-to-back from T+9.
- Backpressure: with 4 ops in flight, hold res_ready_i=0 for 5 cycles -> norm_ce_o=0, no acks, res_* stable. After release, remaining results arrive in order with none lost or duplicated.
- Round-robin wrap: ptr=3, req_i=1001 -> grant 3 then 0. With req_i=0100 only -> grant 2, ptr becomes 3.
- rst asserted with 6 ops in flight and res_valid_o=1 -> next cycle res_valid_o=0, busy_o=0, ptr=0. A new request yields a correct result at +9 with no stale valids.
- flush_i with ops in flight and req_i=0010 -> no ack during the flush cycle, busy_o=0 next cycle, ptr unchanged. The next request completes normally.
